// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle main decoder: opcodes, FSM states,
// datapath mux selects and the bundled control word.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'd0,
    OP_OR    = 4'd1,
    OP_NOR   = 4'd2,
    OP_ADD   = 4'd3,
    OP_SUB   = 4'd4,
    OP_XOR   = 4'd5,
    OP_LSL   = 4'd6,
    OP_LSR   = 4'd7,
    OP_DIV   = 4'd8,
    OP_SLT   = 4'd9,
    OP_LOAD  = 4'd10,
    OP_STORE = 4'd11,
    OP_ADDI  = 4'd12,
    OP_SUBI  = 4'd13,
    OP_BEQ   = 4'd14,
    OP_B     = 4'd15
  } opcode_e;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_IEXEC  = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  typedef enum logic [1:0] {
    SRCB_REG  = 2'b00,
    SRCB_ONE  = 2'b01,
    SRCB_IMM  = 2'b10,
    SRCB_BOFF = 2'b11
  } alusrcb_e;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } aluop_e;

  typedef enum logic [1:0] {
    PC_ALU    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10
  } pcsrc_e;

  typedef struct packed {
    logic     pcwrite;
    logic     irwrite;
    logic     iord;
    logic     memread;
    logic     memwrite;
    logic     regwrite;
    logic     regdst;
    logic     memtoreg;
    logic     alusrca;
    logic     branch;
    logic     illegal;
    alusrcb_e alusrcb;
    aluop_e   aluop;
    pcsrc_e   pcsrc;
  } ctrl_t;

  // Register-register ALU class: everything from AND up to SLT.
  function automatic logic is_r_type(opcode_e op);
    return op <= OP_SLT;
  endfunction

endpackage

// File: rtl/mc_maindec_if.sv
// Controller <-> datapath bundle: opcode and memory handshake in, control
// strobes and debug state out.
interface mc_maindec_if #(
  parameter int OPW = 4
);

  logic [OPW-1:0] op;
  logic           mem_ready;

  logic           pcwrite;
  logic           irwrite;
  logic           iord;
  logic           memread;
  logic           memwrite;
  logic           regwrite;
  logic           regdst;
  logic           memtoreg;
  logic           alusrca;
  logic           branch;
  logic           illegal;
  logic [1:0]     alusrcb;
  logic [1:0]     aluop;
  logic [1:0]     pcsrc;
  logic [3:0]     state;

  modport master (
    input  op, mem_ready,
    output pcwrite, irwrite, iord, memread, memwrite, regwrite, regdst,
           memtoreg, alusrca, branch, illegal, alusrcb, aluop, pcsrc, state
  );

  modport slave (
    output op, mem_ready,
    input  pcwrite, irwrite, iord, memread, memwrite, regwrite, regdst,
           memtoreg, alusrca, branch, illegal, alusrcb, aluop, pcsrc, state
  );

endinterface

// File: rtl/mc_outdec.sv
// Combinational state-to-control decoder; only FETCH, DECODE and IEXEC look
// past the state at the handshake or opcode.
module mc_outdec
  import mc_ctrl_pkg::*;
(
  input  state_e  state_i,
  input  opcode_e opcode_i,
  input  logic    op_legal_i,
  input  logic    mem_ready_i,
  output ctrl_t   ctrl_o
);

  always_comb begin
    // NOTE: every field gets a default before the case, so no path can
    // leave an output unassigned and infer a latch.
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.memread = 1'b1;
        ctrl_o.alusrcb = SRCB_ONE;
        ctrl_o.pcwrite = mem_ready_i;
        ctrl_o.irwrite = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alusrcb = SRCB_BOFF;
        ctrl_o.illegal = ~op_legal_i;
      end
      S_MEMADR: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl_o.iord    = 1'b1;
        ctrl_o.memread = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.iord     = 1'b1;
        ctrl_o.memwrite = 1'b1;
      end
      S_EXEC: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.aluop   = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl_o.regdst   = 1'b1;
        ctrl_o.regwrite = 1'b1;
      end
      S_IEXEC: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_IMM;
        ctrl_o.aluop   = (opcode_i == OP_SUBI) ? ALU_SUB : ALU_ADD;
      end
      S_IWB: begin
        ctrl_o.regwrite = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.aluop   = ALU_SUB;
        ctrl_o.branch  = 1'b1;
        ctrl_o.pcsrc   = PC_BRANCH;
      end
      S_JUMP: begin
        ctrl_o.pcwrite = 1'b1;
        ctrl_o.pcsrc   = PC_JUMP;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mc_maindec.sv
// Multicycle main decoder: state register, next-state logic and the DIV
// dwell counter; control outputs come from mc_outdec.
module mc_maindec
  import mc_ctrl_pkg::*;
#(
  parameter int OPW        = 4,
  parameter int DIV_CYCLES = 4
) (
  input logic          clk,
  input logic          reset,
  mc_maindec_if.master bus
);

  localparam int            CW         = $clog2(DIV_CYCLES + 1);
  localparam logic [CW-1:0] DWELL_LOAD = CW'(DIV_CYCLES - 1);

  state_e        state_q;
  logic [CW-1:0] dwell_q;
  opcode_e       opcode;
  logic          op_legal;
  ctrl_t         ctrl;

  // Anything with bits set above the 4-bit opcode field is illegal.
  assign op_legal = ((bus.op >> 4) == '0);
  assign opcode   = opcode_e'(bus.op[3:0]);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so state and counter both update from
    // the values present before the edge.
    if (reset) begin
      state_q <= S_FETCH;
      dwell_q <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (bus.mem_ready) state_q <= S_DECODE;
        end
        S_DECODE: begin
          if (!op_legal) begin
            state_q <= S_FETCH;
          end else if (is_r_type(opcode)) begin
            state_q <= S_EXEC;
            dwell_q <= DWELL_LOAD;
          end else begin
            case (opcode)
              OP_LOAD, OP_STORE: state_q <= S_MEMADR;
              OP_ADDI, OP_SUBI:  state_q <= S_IEXEC;
              OP_BEQ:            state_q <= S_BRANCH;
              OP_B:              state_q <= S_JUMP;
              default:           state_q <= S_FETCH;
            endcase
          end
        end
        S_MEMADR: begin
          state_q <= (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
        end
        S_MEMRD: begin
          if (bus.mem_ready) state_q <= S_MEMWB;
        end
        S_MEMWB: state_q <= S_FETCH;
        S_MEMWR: begin
          if (bus.mem_ready) state_q <= S_FETCH;
        end
        S_EXEC: begin
          // Only DIV dwells; the counter stops at zero rather than wrapping.
          if (opcode == OP_DIV && dwell_q != '0) begin
            dwell_q <= dwell_q - 1'b1;
          end else begin
            state_q <= S_ALUWB;
            dwell_q <= '0;
          end
        end
        S_ALUWB:  state_q <= S_FETCH;
        S_IEXEC:  state_q <= S_IWB;
        S_IWB:    state_q <= S_FETCH;
        S_BRANCH: state_q <= S_FETCH;
        S_JUMP:   state_q <= S_FETCH;
        default: begin
          state_q <= S_FETCH;
          dwell_q <= '0;
        end
      endcase
    end
  end

  mc_outdec u_outdec (
    .state_i     (state_q),
    .opcode_i    (opcode),
    .op_legal_i  (op_legal),
    .mem_ready_i (bus.mem_ready),
    .ctrl_o      (ctrl)
  );

  assign bus.pcwrite  = ctrl.pcwrite;
  assign bus.irwrite  = ctrl.irwrite;
  assign bus.iord     = ctrl.iord;
  assign bus.memread  = ctrl.memread;
  assign bus.memwrite = ctrl.memwrite;
  assign bus.regwrite = ctrl.regwrite;
  assign bus.regdst   = ctrl.regdst;
  assign bus.memtoreg = ctrl.memtoreg;
  assign bus.alusrca  = ctrl.alusrca;
  assign bus.branch   = ctrl.branch;
  assign bus.illegal  = ctrl.illegal;
  assign bus.alusrcb  = ctrl.alusrcb;
  assign bus.aluop    = ctrl.aluop;
  assign bus.pcsrc    = ctrl.pcsrc;
  assign bus.state    = state_q;

endmodule
